// File: rtl/k12a_lcd_pkg.sv
// Shared types and constants for the k12a HD44780 write sequencer.
// The init ROM is only consumed when LCD_INIT_SEQ_EN is defined.
package k12a_lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        PWRUP
    } lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Power-on init bytes, entry 0 in the least significant byte.
    localparam int unsigned LCD_INIT_LEN = 6;
    localparam logic [8*LCD_INIT_LEN-1:0] LCD_INIT_ROM =
        {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    function automatic logic [7:0] lcd_init_byte(input logic [2:0] idx);
        return LCD_INIT_ROM[idx*8 +: 8];
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execute wait.
    function automatic logic lcd_is_long(input lcd_entry_t e);
        return !e.rs && ((e.data == LCD_CMD_CLEAR) || (e.data[7:1] == LCD_CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/k12a_lcd_fifo.sv
// Synchronous FIFO of LCD write entries; pointers carry one wrap bit so
// full/empty come straight from a pointer compare.
module k12a_lcd_fifo
    import k12a_lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                       cpu_clock,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  lcd_entry_t                 entry_i,
    input  logic                       pop_i,
    output lcd_entry_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    lcd_entry_t    mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= entry_i;
    end

endmodule

// File: rtl/k12a_lcd_ctrl.sv
// HD44780 write sequencer: FIFO-buffered CPU writes replayed with fixed
// setup/enable/hold/execute timing. LCD_INIT_SEQ_EN adds power-up + init ROM.
module k12a_lcd_ctrl
    import k12a_lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned T_SETUP     = 1,
    parameter int unsigned T_EN        = 2,
    parameter int unsigned T_HOLD      = 1,
    parameter int unsigned T_EXEC      = 160,
    parameter int unsigned T_EXEC_LONG = 6000,
    parameter int unsigned T_PWRUP     = 60000
)(
    input  logic       cpu_clock,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic       ovf_clear,
    output logic       fifo_full,
    output logic       busy,
    output logic       ovf,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] LD_SETUP = 16'(T_SETUP - 1);
    localparam logic [15:0] LD_EN    = 16'(T_EN - 1);
    localparam logic [15:0] LD_HOLD  = 16'(T_HOLD - 1);
    localparam logic [15:0] LD_EXEC  = 16'(T_EXEC - 1);
    localparam logic [15:0] LD_LONG  = 16'(T_EXEC_LONG - 1);

`ifdef LCD_INIT_SEQ_EN
    // The power-up wait is preloaded at reset so PWRUP can share the down-counter.
    localparam lcd_state_t  RST_STATE = PWRUP;
    localparam logic [15:0] RST_CNT   = 16'(T_PWRUP - 1);
`else
    localparam lcd_state_t  RST_STATE = IDLE;
    localparam logic [15:0] RST_CNT   = '0;
`endif

    lcd_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    lcd_entry_t  cur_q, cur_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;
    logic        pop;
    logic        drop;
    logic        rom_pending;

    lcd_entry_t  wr_entry;
    lcd_entry_t  head;
    logic        f_full;
    logic        f_empty;
    logic [AW:0] f_count;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0]  rom_idx_q, rom_idx_d;
    logic        rom_done_q, rom_done_d;
    assign rom_pending = ~rom_done_q;
`else
    assign rom_pending = 1'b0;
`endif

    assign wr_entry = '{rs: wr_rs, data: wr_data};

    k12a_lcd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .cpu_clock (cpu_clock),
        .reset_n   (reset_n),
        .push_i    (wr_valid),
        .entry_i   (wr_entry),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (f_full),
        .empty_o   (f_empty),
        .count_o   (f_count)
    );

    assign drop      = wr_valid & f_full & ~pop;
    assign fifo_full = f_full;
    assign busy      = (f_count != '0) | (state_q != IDLE) | rom_pending;
    assign ovf       = ovf_q;
    assign lcd_rs    = cur_q.rs;
    assign lcd_data  = cur_q.data;
    assign lcd_en    = en_q;
    assign lcd_rw    = 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        en_d    = en_q;
        pop     = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        rom_idx_d  = rom_idx_q;
        rom_done_d = rom_done_q;
`endif
        ovf_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : ovf_q);

        case (state_q)
            IDLE: begin
`ifdef LCD_INIT_SEQ_EN
                if (!rom_done_q) begin
                    cur_d     = '{rs: 1'b0, data: lcd_init_byte(rom_idx_q)};
                    cnt_d     = LD_SETUP;
                    state_d   = SETUP;
                    rom_idx_d = rom_idx_q + 3'd1;
                    if (rom_idx_q == 3'(LCD_INIT_LEN - 1)) rom_done_d = 1'b1;
                end else
`endif
                if (!f_empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    cnt_d   = LD_SETUP;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = LD_EN;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = LD_HOLD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = lcd_is_long(cur_q) ? LD_LONG : LD_EXEC;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            EXEC, PWRUP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 16'd1;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            cur_q   <= '0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef LCD_INIT_SEQ_EN
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_idx_q  <= '0;
            rom_done_q <= 1'b0;
        end else begin
            rom_idx_q  <= rom_idx_d;
            rom_done_q <= rom_done_d;
        end
    end
`endif

endmodule
